// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared state encoding and iteration constants for div_seq_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_t;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 5;

endpackage

`default_nettype wire

// File: rtl/not_equal_to_zero_32bits.sv
// ---------------------------------------------------------------------------
// not_equal_to_zero_32bits : 32-bit zero detector, high when any bit is set
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module not_equal_to_zero_32bits (
   input  logic [31:0] i_data,
   output logic        o_not_zero
);

   assign o_not_zero = |i_data;

endmodule

`default_nettype wire

// File: rtl/twos_negate_33.sv
// ---------------------------------------------------------------------------
// twos_negate_33 : conditional 33-bit two's complement negation
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module twos_negate_33 (
   input  logic [32:0] i_val,
   input  logic        i_en,
   output logic [32:0] o_val
);

   assign o_val = i_en ? (~i_val + 33'd1) : i_val;

endmodule

`default_nettype wire

// File: rtl/div_seq_unit.sv
// ---------------------------------------------------------------------------
// div_seq_unit : iterative 32-bit signed restoring divider, one quotient bit
// per cycle. Optional macro DIV_OVF_EXC_EN flags INT_MIN / -1 as an exception.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_seq_unit
   import div_pkg::*;
#(
   parameter int unsigned RDY_HOLD = 0
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        ctrl_div,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic [31:0] data_remainder,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   div_state_t        r_state;
   div_state_t        w_state_nxt;

   logic [CNT_W-1:0]  r_cnt;
   logic [32:0]       r_rem;
   logic [31:0]       r_quo;
   logic [32:0]       r_dvsr;
   logic              r_sign_q;
   logic              r_sign_r;
   logic [31:0]       r_result;
   logic [31:0]       r_remainder;
   logic              r_exc;

   logic              w_b_nz;
   logic              w_ovf;
   logic              w_exc_now;
   logic              w_accept;
   logic              w_last_iter;
   logic [32:0]       w_abs_a;
   logic [32:0]       w_abs_b;
   logic [32:0]       w_rem_sh;
   logic [31:0]       w_quo_sh;
   logic [32:0]       w_trial;
   logic              w_take;
   logic [32:0]       w_fix_q;
   logic [32:0]       w_fix_r;
   logic              w_unused;

   not_equal_to_zero_32bits u_b_zero (
      .i_data     (data_operandB),
      .o_not_zero (w_b_nz)
   );

   // Magnitudes are sign-extended to 33 bits so |INT_MIN| is representable.
   twos_negate_33 u_abs_a (
      .i_val (          {data_operandA[31], data_operandA}),
      .i_en  (data_operandA[31]),
      .o_val (w_abs_a)
   );

   twos_negate_33 u_abs_b (
      .i_val ({data_operandB[31], data_operandB}),
      .i_en  (data_operandB[31]),
      .o_val (w_abs_b)
   );

   twos_negate_33 u_fix_q (
      .i_val ({1'b0, r_quo}),
      .i_en  (r_sign_q),
      .o_val (w_fix_q)
   );

   twos_negate_33 u_fix_r (
      .i_val (r_rem),
      .i_en  (r_sign_r && (r_rem != 33'd0)),
      .o_val (w_fix_r)
   );

`ifdef DIV_OVF_EXC_EN
   assign w_ovf = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
`else
   assign w_ovf = 1'b0;
`endif

   assign w_exc_now   = ~w_b_nz | w_ovf;
   assign w_accept    = ctrl_div && ((r_state == IDLE) || (r_state == DONE));
   assign w_last_iter = (r_cnt == CNT_W'(DIV_ITERS - 1));

   // Remainder stays below |B| <= 2^31, so the shifted value fits in 32 bits
   // and bit 32 of the 33-bit difference is a reliable borrow.
   assign w_rem_sh = {r_rem[31:0], r_quo[31]};
   assign w_quo_sh = {r_quo[30:0], 1'b0};
   assign w_trial  = w_rem_sh - r_dvsr;
   assign w_take   = ~w_trial[32];

   assign w_unused = ^{w_abs_a[32], w_fix_q[32], w_fix_r[32]};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      data_resultRDY = 1'b0;
      busy           = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_exc_now ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last_iter) begin
               w_state_nxt = FIXUP;
            end
         end
         FIXUP: begin
            busy        = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            data_resultRDY = 1'b1;
            if (w_accept) begin
               w_state_nxt = w_exc_now ? DONE : RUN;
            end else if (RDY_HOLD == 0) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvsr      <= '0;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         r_result    <= '0;
         r_remainder <= '0;
         r_exc       <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= w_abs_a[31:0];
         r_dvsr   <= w_abs_b;
         r_sign_q <= data_operandA[31] ^ data_operandB[31];
         r_sign_r <= data_operandA[31];
         r_exc    <= w_exc_now;
         if (w_exc_now) begin
            r_result    <= '0;
            r_remainder <= '0;
         end
      end else if (r_state == RUN) begin
         r_cnt <= r_cnt + CNT_W'(1);
         r_rem <= w_take ? w_trial : w_rem_sh;
         r_quo <= {w_quo_sh[31:1], w_take};
      end else if (r_state == FIXUP) begin
         r_result    <= w_fix_q[31:0];
         r_remainder <= w_fix_r[31:0];
      end
   end

   assign data_result    = r_result;
   assign data_remainder = r_remainder;
   assign data_exception = r_exc;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_div_seq_unit : directed self-checking bench for div_seq_unit
// (instances with RDY_HOLD=0 and RDY_HOLD=1 share the same stimulus)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_seq_unit;

   logic        clock = 1'b0;
   logic        resetn;
   logic        ctrl_div;
   logic [31:0] opA;
   logic [31:0] opB;

   logic [31:0] res0, rem0, res1, rem1;
   logic        exc0, rdy0, busy0, exc1, rdy1, busy1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   div_seq_unit #(.RDY_HOLD(0)) u_dut0 (
      .clock          (clock),
      .resetn         (resetn),
      .ctrl_div       (ctrl_div),
      .data_operandA  (opA),
      .data_operandB  (opB),
      .data_result    (res0),
      .data_remainder (rem0),
      .data_exception (exc0),
      .data_resultRDY (rdy0),
      .busy           (busy0)
   );

   div_seq_unit #(.RDY_HOLD(1)) u_dut1 (
      .clock          (clock),
      .resetn         (resetn),
      .ctrl_div       (ctrl_div),
      .data_operandA  (opA),
      .data_operandB  (opB),
      .data_result    (res1),
      .data_remainder (rem1),
      .data_exception (exc1),
      .data_resultRDY (rdy1),
      .busy           (busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accept edge (cycle 1).
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      ctrl_div = 1'b1;
      opA      = a;
      opB      = b;
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
   endtask

   task automatic wait_rdy(input int c0, output int cyc);
      cyc = c0;
      while (rdy0 !== 1'b1 && cyc < 200) begin
         @(posedge clock);
         #1;
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic eexc, input int elat);
      int cyc;
      start(a, b);
      wait_rdy(1, cyc);
      check({tag, "_lat"}, 32'(cyc), 32'(elat));
      check({tag, "_q"},   res0, eq);
      check({tag, "_r"},   rem0, er);
      check({tag, "_exc"}, {31'd0, exc0}, {31'd0, eexc});
      check({tag, "_q1"},  res1, eq);
      check({tag, "_rdy1"}, {31'd0, rdy1}, 32'd1);
   endtask

   task automatic pulse_check(input string tag);
      @(posedge clock);
      #1;
      check({tag, "_pulse"}, {31'd0, rdy0}, 32'd0);
   endtask

   initial begin
      int  cyc;
      bit  seen;
      resetn   = 1'b0;
      ctrl_div = 1'b0;
      opA      = '0;
      opB      = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      check("rst_q",    res0, 32'd0);
      check("rst_r",    rem0, 32'd0);
      check("rst_flags", {28'd0, exc0, rdy0, busy0, rdy1}, 32'd0);

      run_op("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      pulse_check("p100_7");
      run_op("n100_7", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
      pulse_check("n100_7");
      run_op("p100_n7", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
      pulse_check("p100_n7");
      run_op("div0", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
      pulse_check("div0");
      run_op("p9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
      pulse_check("p9_3");
`ifdef DIV_OVF_EXC_EN
      run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1);
`else
      run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
`endif
      pulse_check("ovf");
      run_op("min_7", 32'h8000_0000, 32'd7, 32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, 34);
      pulse_check("min_7");
      run_op("max_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 34);
      pulse_check("max_1");

      // Requests during RUN must be ignored.
      start(32'd1000, 32'd10);
      repeat (4) begin
         @(posedge clock);
         #1;
      end
      ctrl_div = 1'b1; opA = 32'd7; opB = 32'd0;
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
      check("ign_busy", {31'd0, busy0}, 32'd1);
      repeat (14) begin
         @(posedge clock);
         #1;
      end
      ctrl_div = 1'b1; opA = 32'd3; opB = 32'd1;
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
      wait_rdy(21, cyc);
      check("ign_lat", 32'(cyc), 32'd34);
      check("ign_q",   res0, 32'd100);
      check("ign_exc", {31'd0, exc0}, 32'd0);

      // Back-to-back: accept in the DONE cycle.
      start(-32'sd7, 32'd2);
      check("b2b_rdy_drop", {30'd0, rdy0, rdy1}, 32'd0);
      wait_rdy(1, cyc);
      check("b2b_lat", 32'(cyc), 32'd34);
      check("b2b_q",   res0, 32'hFFFF_FFFD);
      check("b2b_r",   rem0, 32'hFFFF_FFFF);
      pulse_check("b2b");

      // Mid-operation reset.
      start(32'd123456, 32'd789);
      repeat (11) begin
         @(posedge clock);
         #1;
      end
      resetn = 1'b0;
      #1;
      check("mrst_q",    res0, 32'd0);
      check("mrst_r",    rem0, 32'd0);
      check("mrst_flags", {27'd0, exc0, rdy0, busy0, rdy1, busy1}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (rdy0 || rdy1 || busy0) seen = 1'b1;
      end
      check("mrst_no_rdy", {31'd0, seen}, 32'd0);

      // Held ready on the RDY_HOLD=1 instance.
      run_op("hold", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      check("hold_rdy1", {30'd0, rdy1, rdy0}, 32'd2);
      check("hold_q1",   res1, 32'd10);
      start(32'd8, 32'd2);
      check("hold_drop", {31'd0, rdy1}, 32'd0);
      wait_rdy(1, cyc);
      check("hold2_lat", 32'(cyc), 32'd34);
      check("hold2_q1",  res1, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
Iterative 32-bit signed divider for the multdiv path. It produces one quotient bit per cycle using restoring division on operand magnitudes. It consumes the zero flag of the divisor, taken from the existing 32-bit zero detector, to raise a divide-by-zero exception without iterating. Results feed the writeback mux with a ready strobe.

Parameters:
RDY_HOLD, 0, 0 = data_resultRDY is a 1-cycle pulse; 1 = data_resultRDY is held high until the next accepted ctrl_div or reset.

Ports:
clock  input  1  single system clock, rising edge
resetn  input  1  asynchronous, active-low reset
ctrl_div  input  1  start request; sampled every cycle
data_operandA  input  32  dividend, two's complement; sampled on accepted ctrl_div
data_operandB  input  32  divisor, two's complement; sampled on accepted ctrl_div
data_result  output  32  quotient, truncated toward zero
data_remainder  output  32  remainder; sign follows the dividend
data_exception  output  1  divide-by-zero (and overflow, see Optional Feature)
data_resultRDY  output  1  result valid strobe
busy  output  1  high in RUN and FIXUP

Behaviour:
- Reset (async, resetn=0): state=IDLE; data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0, iteration counter=0.
- States: IDLE, RUN, FIXUP, DONE.
- Accept rule: ctrl_div is accepted only in IDLE or DONE. In RUN or FIXUP it is ignored, with no effect on state or registers.
- On accept (cycle 0 edge):
  - Latch |A|, |B|, sign_q = A[31]^B[31], sign_r = A[31].
  - Clear data_exception and data_resultRDY.
  - Divisor zero (not_zero=0 from zero detector on data_operandB): go to DONE with data_result=0, data_remainder=0, data_exception=1. data_resultRDY is high in cycle 1.
  - Otherwise: go to RUN, counter=0.
- RUN, once per cycle:
  - {rem,quo} shift left 1.
  - trial = rem - |B| (33-bit).
  - If trial is non-negative: rem = trial, quo[0] = 1.
  - counter++. Exit to FIXUP after the 32nd RUN edge (counter==31 at that edge).
- FIXUP: negate quo if sign_q; negate rem if sign_r and rem≠0. Register into data_result/data_remainder, then go to DONE.
- DONE: data_resultRDY=1. Latency is ctrl_div in cycle 0 → data_resultRDY high in cycle 34.
- Leaving DONE:
  - RDY_HOLD=0: DONE lasts one cycle, then IDLE.
  - RDY_HOLD=1: remains in DONE until accept.
  - In both cases, data_result, data_remainder and data_exception hold until the next accept.
- Back-to-back: ctrl_div in the DONE cycle is accepted. data_resultRDY deasserts the next cycle.
- Mid-operation reset: immediately aborts to IDLE with all outputs cleared. No stale ready after reset release.
- INT_MIN magnitude: |−2^31| is held in 33 bits internally, so it is exact.

Optional Feature:
Macro: DIV_OVF_EXC_EN
- Defined: A=0x80000000, B=0xFFFFFFFF is detected at accept and handled like divide-by-zero: DONE in cycle 1, data_exception=1, data_result=0, data_remainder=0.
- Undefined: the operation runs normally and yields data_result=0x80000000 (wrapped), data_remainder=0, data_exception=0 at cycle 34.

Decomposition:
- Shared package div_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, FIXUP=2'd2, DONE=2'd3
  - DIV_ITERS=32
  - counter width CNT_W=5
- Sub-module: existing not_equal_to_zero_32bits, instantiated on data_operandB for the divide-by-zero check.
- Magnitude and negation use a small local twos_negate_33 helper module.

Test Plan:
- A=100, B=7 → cycle 34: data_result=14, data_remainder=2, data_exception=0, data_resultRDY pulse 1 cycle.
- A=-100, B=7 → data_result=-14 (0xFFFFFFF2), data_remainder=-2. A=100, B=-7 → result -14, remainder 2.
- A=5, B=0 → cycle 1: data_resultRDY=1, data_exception=1, data_result=0. Next op A=9, B=3 → result 3, exception cleared at accept.
- A=0x80000000, B=-1 → with DIV_OVF_EXC_EN: exception at cycle 1. Without: result 0x80000000 at cycle 34, exception 0.
- Start A=1000, B=10; pulse ctrl_div at cycles 5 and 20 with other operands → ignored, result 100 at cycle 34. Second run: ctrl_div in the DONE cycle → new result exactly 34 cycles later.
- Start op; assert resetn=0 at cycle 12 for 2 cycles → outputs 0 immediately, state IDLE, no resultRDY afterwards. RDY_HOLD=1 run: resultRDY stays high until next ctrl_div.
